// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared states, digit-select codes and default timing constants for the stopwatch controller.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } sw_state_t;
  localparam logic [1:0] SEL_SEC_ONES = 2'd0;
  localparam logic [1:0] SEL_SEC_TENS = 2'd1;
  localparam logic [1:0] SEL_MIN_ONES = 2'd2;
  localparam logic [1:0] SEL_MIN_TENS = 2'd3;
  localparam int TICK_DIV_DEF  = 100_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability-count debouncer and one-cycle press pulse on a debounced rising edge.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk_c,
  input  logic reset_c,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0]    sync;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level;
      press   <= level & ~level_d;
      // any cycle agreeing with the accepted level restarts the stability count
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button/switch conditioning, 1 Hz / 2 Hz timing and run/pause/adjust sequencing for the MM:SS counter.
// Optional macro STOPWATCH_AUTOSTOP_EN: a count issued at 59:59 also drops RUN back to PAUSED.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic       btn_pause,
  input  logic       btn_rst,
  input  logic       sw_adj,
  input  logic [1:0] sw_sel,
  input  logic       at_max,
  output logic       count_en,
  output logic       clr,
  output logic       load,
  output logic [1:0] adj_sel,
  output logic       running,
  output logic       adjusting,
  output logic [3:0] blink_mask
);
  localparam int DW = $clog2(TICK_DIV);
  logic          pause_p;
  logic          rst_p;
  logic [1:0]    adj_sync;
  logic [1:0]    sel_s1;
  logic [1:0]    sel_s2;
  logic          adj_s;
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;
  logic          tick1;
  logic          tick2;
  logic          phase;
  logic          phase_n;
  logic          count_en_n;
  logic          load_n;
  sw_state_t     state;
  sw_state_t     state_n;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk_c  (clk_c),
    .reset_c(reset_c),
    .btn    (btn_pause),
    .press  (pause_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .clk_c  (clk_c),
    .reset_c(reset_c),
    .btn    (btn_rst),
    .press  (rst_p)
  );
  assign adj_s   = adj_sync[1];
  assign tick1   = div == DW'(TICK_DIV - 1);
  assign tick2   = tick1 | (div == DW'(TICK_DIV / 2 - 1));
  assign phase_n = phase ^ tick2;
`ifndef STOPWATCH_AUTOSTOP_EN
  logic unused_at_max;
  assign unused_at_max = at_max;
`endif
  always_comb begin
    state_n = state;
    if (adj_s && state != ADJUST) state_n = ADJUST;
    else if (state == ADJUST && !adj_s) state_n = PAUSED;
    else if (rst_p) state_n = (state == ADJUST) ? ADJUST : PAUSED;
    else if (pause_p) state_n = (state == PAUSED) ? RUN : (state == RUN) ? PAUSED : ADJUST;
`ifdef STOPWATCH_AUTOSTOP_EN
    else if (state == RUN && count_en && at_max) state_n = PAUSED;
`endif
    count_en_n = state == RUN && tick1 && !rst_p && !adj_s;
    load_n     = state == ADJUST && adj_s && pause_p && !rst_p;
    // restarting on start gives a full second before the first count
    div_n      = (rst_p || (state == PAUSED && state_n == RUN) || tick1) ? '0 : div + DW'(1);
  end
  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      state      <= PAUSED;
      div        <= '0;
      phase      <= 1'b0;
      adj_sync   <= '0;
      sel_s1     <= '0;
      sel_s2     <= '0;
      count_en   <= 1'b0;
      clr        <= 1'b0;
      load       <= 1'b0;
      adj_sel    <= '0;
      running    <= 1'b0;
      adjusting  <= 1'b0;
      blink_mask <= '0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      phase      <= phase_n;
      adj_sync   <= {adj_sync[0], sw_adj};
      sel_s1     <= sw_sel;
      sel_s2     <= sel_s1;
      count_en   <= count_en_n;
      clr        <= rst_p;
      load       <= load_n;
      adj_sel    <= sel_s2;
      running    <= state_n == RUN;
      adjusting  <= state_n == ADJUST;
      blink_mask <= (state_n == ADJUST && phase_n) ? sel_onehot(sel_s2) : '0;
    end
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control/sequencing block for the 4-digit MM:SS stopwatch counter.
- Turns raw board buttons and switches into clean single-cycle commands: count enable, synchronous clear, digit load, digit select.
- Generates the 1 Hz count enable and the 2 Hz blink phase from the system clock.
- Owns the run/pause/adjust mode, so the counter datapath stays purely synchronous and mode-free.

Parameters:
- TICK_DIV, 100_000_000: clk_c cycles per 1 Hz count tick; must be even and >= 4.
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a new button level.

Ports:
- clk_c  in  1  system clock
- reset_c  in  1  asynchronous, active-high reset
- btn_pause  in  1  raw pause/load button (asynchronous, bouncy)
- btn_rst  in  1  raw stopwatch-clear button (asynchronous, bouncy)
- sw_adj  in  1  raw adjust-mode switch
- sw_sel  in  2  raw digit select: 00 sec ones, 01 sec tens, 10 min ones, 11 min tens
- at_max  in  1  counter currently reads 59:59 (used only with the optional feature)
- count_en  out  1  one-cycle pulse: counter advances by one second
- clr  out  1  one-cycle pulse: counter clears to 00:00
- load  out  1  one-cycle pulse: counter loads NUM into digit adj_sel
- adj_sel  out  2  synchronized digit select
- running  out  1  high while in RUN
- adjusting  out  1  high while in ADJUST
- blink_mask  out  4  one-hot digit blank mask for the display; bit i = digit i

Behaviour:
- Reset (reset_c high, asynchronous): state PAUSED; all outputs 0; divider = 0; blink phase = 0; synchronizers and debouncers cleared to 0.
- Input synchronization:
  - All four raw inputs pass through a 2-FF synchronizer.
  - sw_adj and sw_sel are used directly after synchronization (no debounce).
- Debounce (per button):
  - Debounced level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any mismatch break restarts the count.
  - A debounced 0->1 transition yields a one-cycle press pulse (pause_p, rst_p).
  - Raw-to-pulse latency = 2 + DB_CYCLES + 1 cycles.
- Divider:
  - Free-running 0..TICK_DIV-1, wraps to 0.
  - tick1 asserted when divider == TICK_DIV-1.
  - tick2 asserted when divider == TICK_DIV/2-1 or TICK_DIV-1.
  - Divider is forced to 0 on rst_p and on the PAUSED->RUN transition, so the first count after start is a full second later.
- FSM (states PAUSED, RUN, ADJUST), priority top-down:
  - sync sw_adj = 1 and state != ADJUST -> ADJUST.
  - ADJUST and sync sw_adj = 0 -> PAUSED.
  - rst_p -> PAUSED, except in ADJUST, which stays ADJUST; clr is pulsed in all states.
  - pause_p in PAUSED -> RUN; in RUN -> PAUSED; in ADJUST -> load pulse, state unchanged.
- Simultaneous events:
  - rst_p and pause_p in the same cycle: rst_p wins and pause_p is discarded (no load, no toggle).
  - rst_p and tick1 in the same cycle: clr only, no count_en.
  - Mode change to ADJUST in the same cycle as tick1: no count_en.
- Outputs: all registered, one cycle after the causing condition.
  - count_en = tick1 while in RUN.
  - adj_sel follows sync sw_sel with 1-cycle delay; load is aligned with the adj_sel value sampled in the same cycle.
  - blink phase toggles on every tick2.
  - blink_mask = one-hot(adj_sel) when in ADJUST and blink phase = 1; otherwise 0.
  - running and adjusting reflect the registered state.
- Reset mid-operation: any in-flight debounce count, divider value or pending pulse is discarded.

Optional Feature:
- Macro: STOPWATCH_AUTOSTOP_EN
- Defined: a count_en issued while at_max = 1 also moves the FSM RUN -> PAUSED in the same cycle. The counter wraps to 00:00 and then holds; running deasserts one cycle after that count_en.
- Undefined: at_max is ignored and the stopwatch wraps 59:59 -> 00:00 and keeps running.

Decomposition:
- Package stopwatch_pkg:
  - state enum (PAUSED = 0, RUN = 1, ADJUST = 2)
  - digit-select constants (SEL_SEC_ONES, SEL_SEC_TENS, SEL_MIN_ONES, SEL_MIN_TENS)
  - default TICK_DIV and DB_CYCLES constants
- Sub-module btn_debounce (synchronizer + stability counter + rising-edge pulse), instantiated once for btn_pause and once for btn_rst.

Test Plan (TICK_DIV=10, DB_CYCLES=4):
- Reset then idle 50 cycles -> count_en, clr, load all 0; running = 0; blink_mask = 0.
- Clean btn_pause press held 10 cycles -> exactly one pause_p; running high 8 cycles after the press edge; first count_en 10 cycles after running rises, then every 10 cycles.
- btn_pause bouncing 1,0,1,0 every 2 cycles, then steady 1 -> no pulse during the bounce; single pulse 7 cycles after the steady level starts.
- sw_adj = 1 while running, sw_sel = 10, one pause press -> adjusting = 1, running = 0, no further count_en; one load pulse with adj_sel = 10; blink_mask alternates 0100/0000 every 5 cycles.
- btn_rst and btn_pause rising in the same cycle while RUN -> one clr pulse, state PAUSED, no load, no toggle; divider restarts from 0.
- With STOPWATCH_AUTOSTOP_EN, at_max = 1 at a tick -> one count_en, then running = 0 and no further count_en; without the macro, count_en continues every 10 cycles.
